// File: rtl/math_expression_pipe.sv
// Four-stage valid/ready pipeline: q = ((C_MUL*c + C_ADD)*(a-b) - D_MUL*d) >>> SHIFT, rmd = low SHIFT bits.
// Define MATH_EXPR_SAT_EN to clamp q to the signed OW range and flag clamped results on out_sat.
module math_expression_pipe #(
   parameter int W     = 32,
   parameter int CW    = 4,
   parameter int C_MUL = 3,
   parameter int C_ADD = 1,
   parameter int D_MUL = 4,
   parameter int SHIFT = 1,
   parameter int TAG_W = 4,
   parameter int OW    = 2*W+CW+3
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [W-1:0]     a,
   input  logic signed [W-1:0]     b,
   input  logic signed [W-1:0]     c,
   input  logic signed [W-1:0]     d,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OW-1:0]    q,
   output logic [SHIFT-1:0]        rmd,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    out_sat
);

   localparam int NW   = 2*W+CW+3;
   localparam int CHW  = W+CW+1;
   localparam int DTW  = W+CW;
   localparam int PW   = 2*W+CW+2;
   localparam int CMIN = -(2**(CW-1));
   localparam int CMAX = 2**(CW-1)-1;

   if (SHIFT < 1) begin : g_bad_shift
      $error("math_expression_pipe: SHIFT must be >= 1");
   end
   if (C_MUL < CMIN || C_MUL > CMAX || C_ADD < CMIN || C_ADD > CMAX ||
       D_MUL < CMIN || D_MUL > CMAX) begin : g_bad_coef
      $error("math_expression_pipe: coefficient does not fit signed CW bits");
   end

   localparam logic signed [CW-1:0] K_CM = C_MUL[CW-1:0];
   localparam logic signed [CW-1:0] K_CA = C_ADD[CW-1:0];
   localparam logic signed [CW-1:0] K_DM = D_MUL[CW-1:0];

   logic                    v0, v1, v2;
   logic signed [W-1:0]     a0, b0, c0, d0;
   logic [TAG_W-1:0]        t0, t1, t2;
   logic signed [CHW-1:0]   cterm1;
   logic signed [W:0]       diff1;
   logic signed [DTW-1:0]   dterm1, dterm2;
   logic signed [PW-1:0]    prod2;

   logic signed [CHW-1:0]   c_x, cm_x, ca_x, cterm_n;
   logic signed [W:0]       diff_n;
   logic signed [DTW-1:0]   d_x, dm_x, dterm_n;
   logic signed [PW-1:0]    cterm_w, diff_w, prod_n;
   logic signed [NW-1:0]    num, sh;
   logic signed [OW-1:0]    q_wrap, q_next;
   logic                    en3, ld2, ld1, ld0;

   always_comb begin
      cm_x    = {{(CHW-CW){K_CM[CW-1]}}, K_CM};
      ca_x    = {{(CHW-CW){K_CA[CW-1]}}, K_CA};
      dm_x    = {{(DTW-CW){K_DM[CW-1]}}, K_DM};
      c_x     = {{(CW+1){c0[W-1]}}, c0};
      cterm_n = c_x * cm_x + ca_x;
      diff_n  = {a0[W-1], a0} - {b0[W-1], b0};
      d_x     = {{CW{d0[W-1]}}, d0};
      dterm_n = d_x * dm_x;
      cterm_w = {{(PW-CHW){cterm1[CHW-1]}}, cterm1};
      diff_w  = {{(PW-W-1){diff1[W]}}, diff1};
      prod_n  = cterm_w * diff_w;
      num     = {prod2[PW-1], prod2} - {{(NW-DTW){dterm2[DTW-1]}}, dterm2};
      sh      = num >>> SHIFT;
      q_wrap  = OW'(sh);
   end

`ifdef MATH_EXPR_SAT_EN
   localparam int QW = NW+OW;
   localparam logic signed [OW-1:0] Q_MIN = {1'b1, {(OW-1){1'b0}}};
   localparam logic signed [OW-1:0] Q_MAX = ~Q_MIN;
   logic sat_n;

   // Result fits iff sign-extending the truncated value reproduces the full one.
   always_comb begin
      sat_n  = (QW'(q_wrap) != QW'(sh));
      q_next = q_wrap;
      if (sat_n) q_next = sh[NW-1] ? Q_MIN : Q_MAX;
   end
`else
   assign q_next  = q_wrap;
   assign out_sat = 1'b0;
`endif

   // A stage may load when it is empty or its current entry moves on this cycle.
   assign en3      = !out_valid || out_ready;
   assign ld2      = !v2 || en3;
   assign ld1      = !v1 || ld2;
   assign ld0      = !v0 || ld1;
   assign in_ready = reset_n && !flush && ld0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v0 <= 1'b0;  v1 <= 1'b0;  v2 <= 1'b0;  out_valid <= 1'b0;
         a0 <= '0;  b0 <= '0;  c0 <= '0;  d0 <= '0;
         t0 <= '0;  t1 <= '0;  t2 <= '0;
         cterm1 <= '0;  diff1 <= '0;  dterm1 <= '0;  dterm2 <= '0;  prod2 <= '0;
         q <= '0;  rmd <= '0;  out_tag <= '0;
`ifdef MATH_EXPR_SAT_EN
         out_sat <= 1'b0;
`endif
      end else if (flush) begin
         v0 <= 1'b0;  v1 <= 1'b0;  v2 <= 1'b0;  out_valid <= 1'b0;
      end else begin
         if (ld0) v0 <= in_valid;
         if (ld0 && in_valid) begin
            a0 <= a;  b0 <= b;  c0 <= c;  d0 <= d;  t0 <= in_tag;
         end
         if (ld1) v1 <= v0;
         if (ld1 && v0) begin
            cterm1 <= cterm_n;  diff1 <= diff_n;  dterm1 <= dterm_n;  t1 <= t0;
         end
         if (ld2) v2 <= v1;
         if (ld2 && v1) begin
            prod2 <= prod_n;  dterm2 <= dterm1;  t2 <= t1;
         end
         if (en3) out_valid <= v2;
         if (en3 && v2) begin
            q       <= q_next;
            rmd     <= num[SHIFT-1:0];
            out_tag <= t2;
`ifdef MATH_EXPR_SAT_EN
            out_sat <= sat_n;
`endif
         end
      end
   end

endmodule
